// File: rtl/strobe_capture_fifo.sv
// strobe_capture_fifo
//   Captures strobed samples with a free-running timestamp into a circular
//   FIFO with first-word-fall-through output. When the FIFO is full, samples
//   are dropped and counted. Once space returns, a single marker record
//   carrying the drop count is queued, so the downstream file-writer can see
//   exactly where data was lost.
//
// Handshake: a record moves downstream in every cycle where out_valid and
//   out_ready are both high at the rising clock edge. out_valid only depends
//   on occupancy and never on out_ready. out_ready has no effect while
//   out_valid is low.
//
// Ports
//   clk          single clock, all state updates on posedge
//   rst          asynchronous, active-high reset
//   sample_en    capture request this cycle
//   sample_data  value to capture
//   out_ready    downstream accepts the head record
//   out_valid    head record present (level != 0)
//   out_data     head data, or drop count when out_mark is set
//   out_tag      timestamp of the head record
//   out_mark     head is a drop-marker record
//   level        current occupancy, 0..DEPTH
//   overflow     sticky, set on the first dropped sample, cleared only by rst
//   dbg_state_o  FSM state for observation: 0 = CAPTURE, 1 = DROPPING
module strobe_capture_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int TAG_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sample_en,
   input  logic [WIDTH-1:0]       sample_data,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_data,
   output logic [TAG_W-1:0]       out_tag,
   output logic                   out_mark,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic                   dbg_state_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {
      CAPTURE  = 1'b0,
      DROPPING = 1'b1
   } state_t;

   // Record storage. Never reset: every read is masked while the FIFO is empty.
   logic [WIDTH-1:0] data_mem [DEPTH];
   logic [TAG_W-1:0] tag_mem  [DEPTH];
   logic             mark_mem [DEPTH];

   state_t           state_q;
   logic [TAG_W-1:0] ts_q;
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic [LW-1:0]    level_d;
   logic [WIDTH-1:0] drop_cnt_q;
   logic [WIDTH-1:0] drop_cnt_d;
   logic             overflow_q;

   logic             pop;
   logic             has_space;
   logic             push;
   logic             push_mark;
   logic [WIDTH-1:0] push_data;

   assign pop = (level_q != '0) && out_ready;

   // A full FIFO still has room this cycle if the head leaves at the same edge.
   assign has_space = (level_q != LW'(DEPTH)) || pop;

   // Count including this cycle's sample. In DROPPING it is either
   // registered (still no space) or written into the marker (space).
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (sample_en && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + WIDTH'(1);
      end
   end

   // Push selection. In DROPPING the marker always wins, and a sample
   // arriving in the same cycle is only counted.
   always_comb begin
      push      = 1'b0;
      push_mark = 1'b0;
      push_data = sample_data;
      unique case (state_q)
         CAPTURE: begin
            if (sample_en && has_space) begin
               push = 1'b1;
            end
         end
         DROPPING: begin
            if (has_space) begin
               push      = 1'b1;
               push_mark = 1'b1;
               push_data = drop_cnt_d;
            end
         end
         default: begin
            push = 1'b0;
         end
      endcase
   end

   always_comb begin
      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_q] <= push_data;
         tag_mem[wr_ptr_q]  <= ts_q;
         mark_mem[wr_ptr_q] <= push_mark;
      end
   end

   // Control FSM, timestamp, pointers and sticky flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CAPTURE;
         ts_q       <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         ts_q    <= ts_q + TAG_W'(1);
         level_q <= level_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         unique case (state_q)
            CAPTURE: begin
               if (sample_en && !has_space) begin
                  state_q    <= DROPPING;
                  drop_cnt_q <= WIDTH'(1);
                  overflow_q <= 1'b1;
               end
            end
            DROPPING: begin
               if (has_space) begin
                  state_q <= CAPTURE;
               end else begin
                  drop_cnt_q <= drop_cnt_d;
               end
            end
            default: begin
               state_q <= CAPTURE;
            end
         endcase
      end
   end

   assign out_valid   = (level_q != '0);
   assign out_data    = out_valid ? data_mem[rd_ptr_q] : '0;
   assign out_tag     = out_valid ? tag_mem[rd_ptr_q]  : '0;
   assign out_mark    = out_valid ? mark_mem[rd_ptr_q] : 1'b0;
   assign level       = level_q;
   assign overflow    = overflow_q;
   assign dbg_state_o = (state_q == DROPPING);

endmodule

// File: tb/tb_strobe_capture_fifo.sv
module tb_strobe_capture_fifo;

   localparam int WIDTH   = 8;
   localparam int DEPTH   = 16;
   localparam int TAG_W   = 16;
   localparam int RW      = 1 + TAG_W + WIDTH;
   localparam int S_DEPTH = 4;
   localparam int S_TAG_W = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   sample_en;
   logic [WIDTH-1:0]       sample_data;
   logic                   out_ready;

   logic                   out_valid;
   logic [WIDTH-1:0]       out_data;
   logic [TAG_W-1:0]       out_tag;
   logic                   out_mark;
   logic [$clog2(DEPTH):0] level;
   logic                   overflow;
   logic                   dbg_state;

   logic                     s_valid;
   logic [WIDTH-1:0]         s_data;
   logic [S_TAG_W-1:0]       s_tag;
   logic                     s_mark;
   logic [$clog2(S_DEPTH):0] s_level;
   logic                     s_overflow;
   logic                     s_dbg;

   int errors = 0;
   int checks = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   strobe_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .sample_en(sample_en), .sample_data(sample_data),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .out_tag(out_tag), .out_mark(out_mark), .level(level),
      .overflow(overflow), .dbg_state_o(dbg_state)
   );

   strobe_capture_fifo #(.WIDTH(WIDTH), .DEPTH(S_DEPTH), .TAG_W(S_TAG_W)) dut_s (
      .clk(clk), .rst(rst), .sample_en(sample_en), .sample_data(sample_data),
      .out_ready(out_ready), .out_valid(s_valid), .out_data(s_data),
      .out_tag(s_tag), .out_mark(s_mark), .level(s_level),
      .overflow(s_overflow), .dbg_state_o(s_dbg)
   );

   // ---------------- reference model (main instance) ----------------
   // Records packed as {mark, tag, data}.
   logic [RW-1:0] exp_q[$];
   int            m_ts;
   bit            m_dropping;
   int            m_cnt;
   bit            m_ovf;

   function automatic void model_reset();
      exp_q.delete();
      m_ts       = 0;
      m_dropping = 1'b0;
      m_cnt      = 0;
      m_ovf      = 1'b0;
   endfunction

   function automatic void model_step(input bit en, input logic [WIDTH-1:0] d, input bit rdy);
      bit            pop;
      bit            space;
      bit            do_push;
      logic [RW-1:0] rec;
      int            cnt_now;
      pop     = (exp_q.size() != 0) && rdy;
      space   = (exp_q.size() < DEPTH) || pop;
      do_push = 1'b0;
      rec     = '0;
      if (!m_dropping) begin
         if (en && space) begin
            do_push = 1'b1;
            rec = {1'b0, TAG_W'(m_ts), d};
         end else if (en) begin
            m_dropping = 1'b1;
            m_cnt      = 1;
            m_ovf      = 1'b1;
         end
      end else begin
         cnt_now = en ? ((m_cnt + 1 > 255) ? 255 : m_cnt + 1) : m_cnt;
         if (space) begin
            do_push    = 1'b1;
            rec        = {1'b1, TAG_W'(m_ts), WIDTH'(cnt_now)};
            m_dropping = 1'b0;
         end else begin
            m_cnt = cnt_now;
         end
      end
      if (pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(rec);
      m_ts = (m_ts + 1) % (1 << TAG_W);
   endfunction

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      chk("m_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("m_level", 32'(level), 32'(exp_q.size()));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_state", 32'(dbg_state), 32'(m_dropping));
      if (exp_q.size() != 0) begin
         chk("m_head", 32'({out_mark, out_tag, out_data}), 32'(exp_q[0]));
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at posedge+1; drives one cycle, checks at negedge, returns at posedge+1.
   task automatic tick(input bit en, input logic [WIDTH-1:0] d, input bit rdy);
      sample_en   = en;
      sample_data = d;
      out_ready   = rdy;
      @(negedge clk);
      model_check();
      model_step(en, d, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      sample_en   = 1'b0;
      sample_data = '0;
      out_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_mark", 32'(out_mark), 32'd0);
      chk("rst_small_valid", 32'(s_valid), 32'd0);
      rst = 1'b0;
      model_reset();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit               en;
      logic [WIDTH-1:0] d;
      bit               rdy;
      bit               e_valid;
      int               e_level;
      bit               e_mark;
      int               e_tag;
      int               e_data;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int en_pct;
      int rdy_pct;

      // Expected values are those seen just after the row's clock edge.
      tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 0,  0};
      tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 0,  0};
      tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 0,  0};
      tbl[3]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1, 1'b0, 3,  'hA5};
      tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 0,  0};
      tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 0,  0};
      tbl[6]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1, 1'b0, 6,  'h3C};
      tbl[7]  = '{1'b1, 8'h5A, 1'b0, 1'b1, 2, 1'b0, 6,  'h3C};
      tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1, 1'b0, 7,  'h5A};
      tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 0,  0};
      tbl[10] = '{1'b1, 8'h77, 1'b1, 1'b1, 1, 1'b0, 10, 'h77};
      tbl[11] = '{1'b1, 8'h88, 1'b1, 1'b1, 1, 1'b0, 11, 'h88};
      tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 0,  0};

      model_reset();
      do_reset();
      for (int i = 0; i < 13; i++) begin
         tick(tbl[i].en, tbl[i].d, tbl[i].rdy);
         chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
         chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].e_level));
         chk($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'd0);
         if (tbl[i].e_valid) begin
            chk($sformatf("tbl%0d_mark", i), 32'(out_mark), 32'(tbl[i].e_mark));
            chk($sformatf("tbl%0d_tag", i), 32'(out_tag), 32'(tbl[i].e_tag));
            chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].e_data));
         end
      end

      // Fill, overflow, then marker with drop count 4 and in-order drain.
      do_reset();
      for (int i = 0; i < 17; i++) tick(1'b1, 8'(i + 16), 1'b0);
      chk("full_level", 32'(level), 32'd16);
      chk("full_overflow", 32'(overflow), 32'd1);
      chk("full_state", 32'(dbg_state), 32'd1);
      for (int i = 0; i < 3; i++) tick(1'b1, 8'hEE, 1'b0);
      tick(1'b0, 8'h00, 1'b1);
      chk("mk_level", 32'(level), 32'd16);
      chk("mk_state", 32'(dbg_state), 32'd0);
      for (int i = 1; i < 16; i++) begin
         chk($sformatf("drain%0d_data", i), 32'(out_data), 32'(i + 16));
         chk($sformatf("drain%0d_tag", i), 32'(out_tag), 32'(i));
         tick(1'b0, 8'h00, 1'b1);
      end
      chk("mk_head_mark", 32'(out_mark), 32'd1);
      chk("mk_head_data", 32'(out_data), 32'd4);
      chk("mk_head_tag", 32'(out_tag), 32'd20);
      tick(1'b0, 8'h00, 1'b1);
      chk("mk_empty", 32'(level), 32'd0);
      chk("mk_ovf_sticky", 32'(overflow), 32'd1);

      // Full FIFO, simultaneous pop and capture.
      do_reset();
      for (int i = 0; i < 16; i++) tick(1'b1, 8'(i), 1'b0);
      tick(1'b1, 8'hC3, 1'b1);
      chk("pp_level", 32'(level), 32'd16);
      chk("pp_overflow", 32'(overflow), 32'd0);
      chk("pp_state", 32'(dbg_state), 32'd0);
      chk("pp_head_tag", 32'(out_tag), 32'd1);
      for (int i = 0; i < 17; i++) tick(1'b0, 8'h00, 1'b1);

      // Timestamp wrap on the 4-bit tag instance.
      do_reset();
      for (int i = 0; i < 15; i++) tick(1'b0, 8'h00, 1'b1);
      tick(1'b1, 8'h11, 1'b1);
      chk("wrap_tag15", 32'(s_tag), 32'd15);
      chk("wrap_data15", 32'(s_data), 32'h11);
      tick(1'b1, 8'h22, 1'b1);
      chk("wrap_tag0", 32'(s_tag), 32'd0);
      chk("wrap_data0", 32'(s_data), 32'h22);
      chk("wrap_level", 32'(s_level), 32'd1);

      // Drop-count saturation on both instances.
      do_reset();
      for (int i = 0; i < 304; i++) tick(1'b1, 8'(i), 1'b0);
      tick(1'b0, 8'h00, 1'b1);
      chk("sat_state", 32'(s_dbg), 32'd0);
      for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1);
      chk("sat_mark", 32'(s_mark), 32'd1);
      chk("sat_data", 32'(s_data), 32'd255);
      chk("sat_overflow", 32'(s_overflow), 32'd1);
      for (int i = 0; i < 14; i++) tick(1'b0, 8'h00, 1'b1);

      // Asynchronous reset mid-cycle while dropping.
      do_reset();
      for (int i = 0; i < 18; i++) tick(1'b1, 8'(i), 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_level", 32'(level), 32'd0);
      chk("arst_overflow", 32'(overflow), 32'd0);
      chk("arst_state", 32'(dbg_state), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      tick(1'b1, 8'h5D, 1'b0);
      chk("arst_first_tag", 32'(out_tag), 32'd0);
      chk("arst_first_data", 32'(out_data), 32'h5D);
      chk("arst_first_level", 32'(level), 32'd1);

      // Randomized traffic against the model.
      do_reset();
      for (int p = 0; p < 4; p++) begin
         case (p)
            0:       begin en_pct = 70; rdy_pct = 30; end
            1:       begin en_pct = 50; rdy_pct = 50; end
            2:       begin en_pct = 90; rdy_pct = 95; end
            default: begin en_pct = 30; rdy_pct = 80; end
         endcase
         for (int i = 0; i < 500; i++) begin
            tick($urandom_range(0, 99) < en_pct, 8'($urandom), $urandom_range(0, 99) < rdy_pct);
         end
      end
      for (int i = 0; i < 20; i++) tick(1'b0, 8'h00, 1'b1);

      // ---------------- final report ----------------
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
